// File: rtl/blur_filter.sv
// ---------------------------------------------------------------------------
// blur_filter
//
// Purpose:
//   A streaming 1-D horizontal blur over a 5-pixel window.
//   The kernel weights are 1,4,8,4,1, so they sum to 18.
//   The weighted sum is scaled by 1/32 + 1/64 + 1/128, which is about 7/128.
//   That brings the unity-gain result back into pixel range.
//   The final value is saturated to the pixel maximum.
//
//   Each accepted pixel produces exactly one output. The path is:
//     PHASE1  -> t1 register
//     PHASE2  -> t2 register
//     PHASE3  -> out_pixel register
//     OUTPUT  -> holds the result until the consumer takes it
//   In OUTPUT, a new pixel can be accepted on the same edge that hands off
//   the result. That gives one pixel every 4 cycles at peak.
//
//   A start-of-line pixel fills the whole window with its own value, which
//   replicates the left edge. The right edge is not replicated.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   n_rst      in   asynchronous active-low reset
//   in_valid   in   in_pixel/in_sol are valid this cycle
//   in_ready   out  block accepts input this cycle
//   in_pixel   in   [PIXEL_BITS] unsigned input pixel
//   in_sol     in   start of line, qualified by in_valid
//   out_valid  out  out_pixel holds a result
//   out_ready  in   consumer accepts out_pixel
//   out_pixel  out  [PIXEL_BITS] unsigned blurred pixel
//
// Parameters:
//   PIXEL_BITS  pixel width, minimum 4, default 8.
//               The accumulator width is always PIXEL_BITS+5.
//
// Configuration macro:
//   BLUR_ROUND_EN  when defined, each of the three scale terms rounds to
//                  nearest instead of truncating. Interface, latency and
//                  handshake are the same in both builds.
// ---------------------------------------------------------------------------
module blur_filter #(
    parameter int PIXEL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIXEL_BITS-1:0] in_pixel,
    input  logic                  in_sol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIXEL_BITS-1:0] out_pixel
);

    // The sum of 18*max fits in PIXEL_BITS+5 bits.
    // This leaves headroom for the rounding offsets.
    localparam int ACC_BITS = PIXEL_BITS + 5;
    localparam logic [PIXEL_BITS-1:0] PIX_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PHASE1 = 3'd1,
        PHASE2 = 3'd2,
        PHASE3 = 3'd3,
        OUTPUT = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [PIXEL_BITS-1:0] win_q [0:4];
    logic [PIXEL_BITS-1:0] win_d [0:4];
    logic [ACC_BITS-1:0]   t1_q, t1_d;
    logic [ACC_BITS-1:0]   t2_q, t2_d;
    logic [PIXEL_BITS-1:0] out_q, out_d;

    logic                  accept;
    logic [ACC_BITS-1:0]   s5, s6, s7;
    logic [ACC_BITS-1:0]   scaleSum;
    logic [PIXEL_BITS-1:0] pixSat;

    function automatic logic [ACC_BITS-1:0] ext(input logic [PIXEL_BITS-1:0] p);
        return ACC_BITS'(p);
    endfunction

    assign accept    = in_valid && in_ready;
    assign out_pixel = out_q;

    // Next state and handshake outputs.
    // in_ready in OUTPUT depends on out_ready combinationally.
    // This is what allows a back-to-back accept on the hand-off edge.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = PHASE1;
            end
            PHASE1: state_d = PHASE2;
            PHASE2: state_d = PHASE3;
            PHASE3: state_d = OUTPUT;
            OUTPUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? PHASE1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window update on an accepted pixel.
    // A start-of-line pixel floods all five taps with its own value.
    always_comb begin
        for (int i = 0; i < 5; i++) win_d[i] = win_q[i];
        if (accept) begin
            if (in_sol) begin
                for (int i = 0; i < 5; i++) win_d[i] = in_pixel;
            end else begin
                for (int i = 0; i < 4; i++) win_d[i] = win_q[i+1];
                win_d[4] = in_pixel;
            end
        end
    end

    // Scale terms.
    // Each term is shifted on its own, so the truncation (or rounding) of
    // each term adds to the final result.
    always_comb begin
`ifdef BLUR_ROUND_EN
        s5 = (t2_q + ACC_BITS'(16)) >> 5;
        s6 = (t2_q + ACC_BITS'(32)) >> 6;
        s7 = (t2_q + ACC_BITS'(64)) >> 7;
`else
        s5 = t2_q >> 5;
        s6 = t2_q >> 6;
        s7 = t2_q >> 7;
`endif
        scaleSum = s5 + s6 + s7;
        pixSat   = (scaleSum > ACC_BITS'(PIX_MAX)) ? PIX_MAX : scaleSum[PIXEL_BITS-1:0];
    end

    // Two-step accumulation, then the scaled result.
    // Each register loads only in its own phase.
    always_comb begin
        t1_d  = t1_q;
        t2_d  = t2_q;
        out_d = out_q;
        if (state_q == PHASE1)
            t1_d = ext(win_q[0]) + (ext(win_q[1]) << 2) + (ext(win_q[2]) << 3);
        if (state_q == PHASE2)
            t2_d = t1_q + (ext(win_q[3]) << 2) + ext(win_q[4]);
        if (state_q == PHASE3)
            out_d = pixSat;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 5; i++) win_q[i] <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 5; i++) win_q[i] <= win_d[i];
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: doc/blur_filter.md
BLUR_FILTER -- requirements
Module: blur_filter

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 8, meaning width of input and output pixels (minimum 4).
REQ-002 SHALL derive ACC_BITS = PIXEL_BITS+5 internally; it SHALL NOT be user-settable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_pixel/in_sol valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-007 in_pixel  input  PIXEL_BITS  incoming pixel, unsigned.
REQ-008 in_sol  input  1  start of line, qualified by in_valid.
REQ-009 out_valid  output  1  out_pixel holds a result.
REQ-010 out_ready  input  1  consumer accepts out_pixel.
REQ-011 out_pixel  output  PIXEL_BITS  blurred pixel, unsigned.

Function
REQ-012 SHALL keep a 5-entry window w0..w4 (w4 newest); on each accepted pixel the window shifts (w0<=w1 .. w3<=w4, w4<=in_pixel).
REQ-013 On an accepted pixel with in_sol=1, all five entries SHALL load in_pixel (left-edge replication).
REQ-014 FSM states IDLE, PHASE1, PHASE2, PHASE3, OUTPUT; IDLE->PHASE1 on transfer; PHASE1->PHASE2->PHASE3->OUTPUT unconditionally.
REQ-015 PHASE1 SHALL register t1 = w0 + 4*w1 + 8*w2 (ACC_BITS, no overflow possible).
REQ-016 PHASE2 SHALL register t2 = t1 + 4*w3 + w4.
REQ-017 PHASE3 SHALL register out_pixel = (t2>>5)+(t2>>6)+(t2>>7), each term truncated independently, saturated to 2^PIXEL_BITS-1.
REQ-018 in_ready SHALL be 1 in IDLE, and in OUTPUT when out_ready=1; 0 otherwise.
REQ-019 out_valid SHALL be 1 only in OUTPUT; out_pixel SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 OUTPUT->IDLE when out_ready=1 and in_valid=0; OUTPUT->PHASE1 when out_ready=1 and in_valid=1 (back-to-back accept, window shifts that edge).
REQ-021 Latency: transfer at edge k -> out_valid=1 after edge k+3; peak throughput one pixel per 4 cycles.
REQ-022 in_valid while in_ready=0 SHALL be ignored; window unchanged.
REQ-023 No right-edge replication; each accepted pixel yields exactly one output.

Reset
REQ-024 n_rst=0 SHALL immediately force state IDLE, window, t1, t2, out_pixel to 0, out_valid=0, in_ready=1 (after release).
REQ-025 Reset mid-computation or mid-OUTPUT SHALL discard the pending result; no output after release until a new transfer.

Configuration
REQ-026 Macro BLUR_ROUND_EN: when defined, each scale term SHALL be (t2+2^(s-1))>>s for s=5,6,7, then saturated; when undefined, truncation per REQ-017.
REQ-027 Macro SHALL not change interface, latency or handshake.

Verification
REQ-028 PIXEL_BITS=8: sol pixel 100, out_ready=1 -> out_pixel=98 after 3 edges, both configurations.
REQ-029 Sol pixel 255 -> out_pixel=249 without BLUR_ROUND_EN, 251 with it.
REQ-030 Sol 0, then 0,0,0,200, then 0,0 -> last three outputs 10, 43, 87 (truncation build).
REQ-031 out_ready=0 for 5 cycles while in OUTPUT -> out_valid held 1, out_pixel stable, in_ready=0, in_valid ignored; then out_ready=1 with in_valid=1 -> direct OUTPUT->PHASE1 transfer.
REQ-032 Assert n_rst in PHASE2 -> outputs 0 at once; after release, out_valid stays 0 until new transfer; next sol 100 -> 98.
REQ-033 Continuous in_valid/out_ready=1 stream of 20 pixels -> exactly 20 outputs, one per 4 cycles, matching a reference model.
